// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer: periodic ADC channel-scan controller.
// Emits one 16-bit command per enabled channel in sweeps that start every
// `period` cycles. Command issue stalls under `buf_full` backpressure. The
// block reports sweep completion, a completed-sweep count and a sticky
// overrun flag when a sweep outlasts its period.
module adc_scan_sequencer #(
  parameter int NUM_CH   = 8,
  parameter int PERIOD_W = 16
) (
  input  logic                ti_clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                stop,
  input  logic [PERIOD_W-1:0] period,
  input  logic [NUM_CH-1:0]   ch_mask,
  input  logic [15:0]         cmd_base,
  input  logic                buf_full,
  output logic [15:0]         cmd,
  output logic                cmd_en,
  output logic                busy,
  output logic                sweep_done,
  output logic [15:0]         sweep_count,
  output logic                overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  localparam logic [3:0]          LAST_IDX = 4'(NUM_CH - 1);
  localparam logic [PERIOD_W-1:0] ONE      = PERIOD_W'(1);

  state_e              r_state;
  state_e              w_state_nxt;

  // Per-sweep snapshot of the configuration inputs.
  logic [15:0]         r_mask;
  logic [15:0]         r_base;
  logic [PERIOD_W-1:0] r_period;

  logic [PERIOD_W-1:0] r_timer;
  logic [3:0]          r_idx;
  logic                r_stop_pend;

  logic [15:0]         r_cmd;
  logic                r_cmd_en;
  logic                r_busy;
  logic                r_sweep_done;
  logic [15:0]         r_sweep_count;
  logic                r_overrun;

  logic                w_first_start;  // start accepted from IDLE
  logic                w_sweep_start;  // any entry into SCAN
  logic                w_advance;      // current index is finished this edge
  logic                w_issue;        // current index emits a command
  logic                w_done;         // last index finished this edge
  logic                w_mask_bit;
  logic                w_timer_low;    // timer is 0 or reaches 0 this edge
  logic [15:0]         w_cmd;

  // State register.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      // NOTE: every sequential assignment is non-blocking so all registers
      // update from the same pre-edge values, regardless of statement order.
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-edge control decode.
  always_comb begin
    // NOTE: defaults come first so every path assigns every signal; a
    // missing assignment here would otherwise infer a latch.
    w_state_nxt   = r_state;
    w_first_start = 1'b0;
    w_sweep_start = 1'b0;
    w_advance     = 1'b0;
    w_issue       = 1'b0;
    w_done        = 1'b0;
    w_mask_bit    = r_mask[r_idx];
    w_timer_low   = (r_timer <= ONE);
    w_cmd         = r_base;
    w_cmd[11:8]   = r_idx;

    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_state_nxt   = ST_SCAN;
          w_first_start = 1'b1;
          w_sweep_start = 1'b1;
        end
      end
      ST_SCAN: begin
        // A disabled channel always advances; an enabled one waits for room.
        w_advance = !w_mask_bit || !buf_full;
        w_issue   = w_mask_bit && !buf_full;
        if (w_advance && (r_idx == LAST_IDX)) begin
          w_done      = 1'b1;
          w_state_nxt = (r_stop_pend || stop) ? ST_IDLE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Stop wins over a sweep start falling on the same edge.
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (w_timer_low) begin
          w_state_nxt   = ST_SCAN;
          w_sweep_start = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sweep datapath: snapshot, index, period timer and registered outputs.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mask        <= '0;
      r_base        <= '0;
      r_period      <= '0;
      r_timer       <= '0;
      r_idx         <= '0;
      r_stop_pend   <= 1'b0;
      r_cmd         <= '0;
      r_cmd_en      <= 1'b0;
      r_busy        <= 1'b0;
      r_sweep_done  <= 1'b0;
      r_sweep_count <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_cmd_en     <= w_issue;
      r_sweep_done <= w_done;
      r_busy       <= (w_state_nxt != ST_IDLE);

      // cmd holds its last value between strobes.
      if (w_issue) r_cmd <= w_cmd;

      if (w_sweep_start) begin
        r_mask   <= 16'(ch_mask);
        r_base   <= cmd_base;
        r_period <= period;
        r_timer  <= period;
        r_idx    <= '0;
      end else begin
        if ((r_state != ST_IDLE) && (r_timer != '0)) r_timer <= r_timer - ONE;
        if (w_done)         r_idx <= '0;
        else if (w_advance) r_idx <= r_idx + 4'd1;
      end

      if (w_sweep_start)                     r_stop_pend <= 1'b0;
      else if ((r_state == ST_SCAN) && stop) r_stop_pend <= 1'b1;

      if (w_first_start)  r_sweep_count <= '0;
      else if (w_done)    r_sweep_count <= r_sweep_count + 16'd1;

      // The timer hitting zero while still scanning means the sweep missed
      // its slot; period 0 is continuous mode and never flags.
      if (w_first_start) begin
        r_overrun <= 1'b0;
      end else if ((r_state == ST_SCAN) && (r_period != '0) && w_timer_low) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign cmd         = r_cmd;
  assign cmd_en      = r_cmd_en;
  assign busy        = r_busy;
  assign sweep_done  = r_sweep_done;
  assign sweep_count = r_sweep_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Testbench for adc_scan_sequencer. Per-edge input tables drive the DUT and
// a sweep-level timeline model predicts every registered output per edge.
module tb_adc_scan_sequencer;

  localparam int NC = 8;
  localparam int PW = 16;
  localparam int H  = 512;

  logic          ti_clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [PW-1:0] period;
  logic [NC-1:0] ch_mask;
  logic [15:0]   cmd_base;
  logic          buf_full;
  logic [15:0]   cmd;
  logic          cmd_en;
  logic          busy;
  logic          sweep_done;
  logic [15:0]   sweep_count;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus tables, indexed by edge number within a scenario.
  logic [NC-1:0] a_mask [H];
  logic [15:0]   a_base [H];
  logic [PW-1:0] a_per  [H];
  bit            a_bf   [H];
  bit            a_start[H];

  // Expected outputs after each edge.
  bit            e_en   [H];
  logic [15:0]   e_cmd  [H];
  bit            e_done [H];
  int            e_cnt  [H];
  bit            e_ovr  [H];
  bit            e_busy [H];
  int            end_edge;
  logic [15:0]   last_cmd;

  always #5 ti_clk = ~ti_clk;

  adc_scan_sequencer #(.NUM_CH(NC), .PERIOD_W(PW)) dut (
    .ti_clk      (ti_clk),
    .rst_n       (rst_n),
    .start       (start),
    .stop        (stop),
    .period      (period),
    .ch_mask     (ch_mask),
    .cmd_base    (cmd_base),
    .buf_full    (buf_full),
    .cmd         (cmd),
    .cmd_en      (cmd_en),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .sweep_count (sweep_count),
    .overrun     (overrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, " cmd"},         32'(cmd),         32'd0);
    check({tag, " cmd_en"},      32'(cmd_en),      32'd0);
    check({tag, " busy"},        32'(busy),        32'd0);
    check({tag, " sweep_done"},  32'(sweep_done),  32'd0);
    check({tag, " sweep_count"}, 32'(sweep_count), 32'd0);
    check({tag, " overrun"},     32'(overrun),     32'd0);
  endtask

  // Fill the stimulus tables; chg_pct is the per-edge chance that the
  // configuration inputs change (exercises mid-sweep input changes).
  task automatic fill(input logic [NC-1:0] m, input logic [15:0] b, input logic [PW-1:0] p,
                      input int bf_pct, input int chg_pct);
    for (int t = 0; t < H; t++) begin
      if (t == 0) begin
        a_mask[t] = m; a_base[t] = b; a_per[t] = p;
      end else if ($urandom_range(99) < 32'(chg_pct)) begin
        a_mask[t] = NC'($urandom); a_base[t] = 16'($urandom); a_per[t] = PW'($urandom_range(30));
      end else begin
        a_mask[t] = a_mask[t-1]; a_base[t] = a_base[t-1]; a_per[t] = a_per[t-1];
      end
      a_bf[t]    = ($urandom_range(99) < 32'(bf_pct));
      a_start[t] = 1'b0;
    end
  endtask

  // Sweep timeline: a sweep starting at edge s processes one channel per
  // edge, an enabled channel waits out every buf_full edge, and the next
  // sweep starts at s+period or one edge after completion, whichever is later.
  task automatic build_model(input int stop_edge);
    int s, t, c, nxt, cnt, ovr_edge;
    logic [NC-1:0] m;
    logic [15:0]   b;
    logic [PW-1:0] p;
    for (int x = 0; x < H; x++) begin
      e_en[x] = 0; e_cmd[x] = '0; e_done[x] = 0;
    end
    s = 0; end_edge = -1; ovr_edge = H;
    while (end_edge < 0) begin
      m = a_mask[s]; b = a_base[s]; p = a_per[s];
      t = s;
      for (int i = 0; i < NC; i++) begin
        t++;
        if (m[i]) begin
          while (a_bf[t] && t < H - 8) t++;
          e_en[t]  = 1;
          e_cmd[t] = {b[15:12], 4'(i), b[7:0]};
        end
      end
      c = t;
      if (c >= H - 8) begin
        $display("FAIL model horizon exceeded at edge %0d", c);
        $fatal(1, "stimulus too long");
      end
      e_done[c] = 1;
      if (p != 0 && s + int'(p) <= c && s + int'(p) < ovr_edge) ovr_edge = s + int'(p);
      nxt = (p != 0 && s + int'(p) > c) ? s + int'(p) : c + 1;
      if (stop_edge > s && stop_edge <= c)        end_edge = c;
      else if (stop_edge > c && stop_edge <= nxt) end_edge = stop_edge;
      else                                        s = nxt;
    end
    cnt = 0;
    for (int x = 0; x < H; x++) begin
      cnt      += int'(e_done[x]);
      e_cnt[x]  = cnt;
      e_ovr[x]  = (x >= ovr_edge);
      e_busy[x] = (x < end_edge);
    end
    // Spurious start pulses while active must be ignored.
    for (int x = 1; x < end_edge; x++) a_start[x] = ($urandom_range(9) == 0);
  endtask

  task automatic drive(input int t, input int stop_edge);
    start    = (t == 0) ? 1'b1 : a_start[t];
    stop     = (t == stop_edge);
    ch_mask  = a_mask[t];
    cmd_base = a_base[t];
    period   = a_per[t];
    buf_full = a_bf[t];
  endtask

  task automatic drive_idle();
    start = 1'b0; stop = 1'b0; buf_full = 1'b0;
  endtask

  // Run one scenario from IDLE; abort_edge >= 0 asserts reset mid-cycle
  // after that edge has been checked.
  task automatic run_scn(input string name, input int stop_edge, input int abort_edge);
    string tg;
    build_model(stop_edge);
    @(negedge ti_clk);
    drive(0, stop_edge);
    for (int t = 0; t <= end_edge + 3; t++) begin
      @(posedge ti_clk);
      @(negedge ti_clk);
      tg = $sformatf("%s t=%0d", name, t);
      if (e_en[t]) last_cmd = e_cmd[t];
      check({tg, " cmd_en"},      32'(cmd_en),      32'(e_en[t]));
      check({tg, " cmd"},         32'(cmd),         32'(last_cmd));
      check({tg, " sweep_done"},  32'(sweep_done),  32'(e_done[t]));
      check({tg, " sweep_count"}, 32'(sweep_count), 32'(e_cnt[t]));
      check({tg, " overrun"},     32'(overrun),     32'(e_ovr[t]));
      check({tg, " busy"},        32'(busy),        32'(e_busy[t]));
      if (t == abort_edge) begin
        drive(t + 1, stop_edge);
        #2 rst_n = 1'b0;
        #1 check_zero({name, " async_reset"});
        last_cmd = '0;
        break;
      end
      if (t + 1 > end_edge) drive_idle();
      else                  drive(t + 1, stop_edge);
    end
    drive_idle();
  endtask

  task automatic idle_cycles(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ti_clk);
      ch_mask = NC'($urandom); cmd_base = 16'($urandom); period = PW'($urandom);
      buf_full = 1'($urandom);
      check($sformatf("%s idle%0d busy", name, i),   32'(busy),   32'd0);
      check($sformatf("%s idle%0d cmd_en", name, i), 32'(cmd_en), 32'd0);
      check($sformatf("%s idle%0d count", name, i),  32'(sweep_count), 32'd0);
      check($sformatf("%s idle%0d cmd", name, i),    32'(cmd),    32'(last_cmd));
    end
  endtask

  initial begin
    logic [NC-1:0] m;
    logic [PW-1:0] p;
    int            r;

    // Reset with random activity on the inputs.
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; buf_full = 1'($urandom);
    ch_mask = NC'($urandom); cmd_base = 16'($urandom); period = PW'($urandom);
    last_cmd = '0;
    repeat (3) @(negedge ti_clk);
    check_zero("reset");
    drive_idle();
    rst_n = 1'b1;
    idle_cycles("post_reset", 4);

    fill(8'hFF, 16'hA0C3, 16'd20, 0, 0);
    run_scn("full", 45, -1);

    fill(8'h05, 16'hA0C3, 16'd20, 0, 0);
    run_scn("mask_stop_wait", 12, -1);

    fill(8'hFF, 16'hA0C3, 16'd20, 0, 0);
    for (int t = 4; t <= 8; t++) a_bf[t] = 1;
    run_scn("stall", 30, -1);

    fill(8'hFF, 16'hA0C3, 16'd4, 0, 0);
    run_scn("overrun", 40, -1);

    fill(8'hFF, 16'h5E21, 16'd8, 0, 0);
    run_scn("period_nc", 30, -1);

    fill(8'hFF, 16'h5E21, 16'd9, 0, 0);
    run_scn("period_nc1", 30, -1);

    fill(8'hFF, 16'hA0C3, 16'd0, 0, 0);
    run_scn("back_to_back", 30, -1);

    fill(8'h00, 16'hA0C3, 16'd10, 0, 0);
    run_scn("zero_mask", 25, -1);

    fill(8'hFF, 16'hA0C3, 16'd20, 0, 0);
    run_scn("stop_idx2", 3, -1);

    for (int k = 0; k < 12; k++) begin
      r = int'($urandom_range(5));
      m = (r == 0) ? '0 : (r == 1) ? '1 : NC'($urandom);
      r = int'($urandom_range(3));
      p = (r == 0) ? '0 : (r == 1) ? PW'($urandom_range(1, 9)) : PW'($urandom_range(10, 30));
      fill(m, 16'($urandom), p, int'($urandom_range(30)), int'($urandom_range(15)));
      run_scn($sformatf("rnd%0d", k), int'($urandom_range(150, 5)), -1);
    end

    // Abort at index 4 of the second sweep; reset stays low across an edge.
    fill(8'hFF, 16'hA0C3, 16'd10, 0, 0);
    run_scn("abort", 200, 14);
    @(negedge ti_clk);
    check_zero("abort held");
    drive_idle();
    rst_n = 1'b1;
    idle_cycles("post_abort", 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
